// File: rtl/player_shot_ctrl.sv
// player_shot_ctrl: player projectile scheduler.
// Owns a pool of NUM_SHOTS shot slots, launches a shot at the player's nose on a
// fire event, rate-limits launches with a frame cooldown, moves active shots up
// each enabled frame and retires them on a hit or when they leave the top edge.
// Optional build macro: PLAYER_SHOT_AUTOFIRE_EN (level-triggered fire; default is
// rising-edge fire).
module player_shot_ctrl #(
    parameter int unsigned NUM_SHOTS  = 4,
    parameter int unsigned SHOT_STEP  = 4,
    parameter int unsigned COOLDOWN   = 8,
    parameter int unsigned SHOT_Y_MIN = 0
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic                      enable,
    input  logic                      fire_req,
    input  logic [9:0]                PlayerX,
    input  logic [9:0]                PlayerY,
    input  logic [9:0]                PlayerS,
    input  logic [NUM_SHOTS-1:0]      hit,
    output logic [NUM_SHOTS*10-1:0]   ShotX,
    output logic [NUM_SHOTS*10-1:0]   ShotY,
    output logic [NUM_SHOTS-1:0]      shot_active,
    output logic                      fire_ack,
    output logic [15:0]               shots_fired
);

    localparam int unsigned IDX_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
    localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN);
    localparam logic [9:0]      STEP      = 10'(SHOT_STEP);
    // A shot whose Y is below this cannot take another full step without
    // crossing the top bound, so it retires instead of moving.
    localparam logic [9:0]      Y_RETIRE  = 10'(SHOT_Y_MIN + SHOT_STEP);
    localparam logic [10:0]     Y_MIN_EXT = 11'(SHOT_Y_MIN);

    // Registered state beyond the output registers.
    logic [CD_W-1:0] cooldown;
    logic            fire_q;

    // Decoded per-cycle control.
    logic             fire_event;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [10:0]      y_floor;
    logic             player_y_ok;
    logic             launch;
    logic [9:0]       launch_y;

    // Next-state values.
    logic [NUM_SHOTS-1:0]    active_d;
    logic [NUM_SHOTS*10-1:0] shot_x_d;
    logic [NUM_SHOTS*10-1:0] shot_y_d;
    logic [CD_W-1:0]         cooldown_d;
    logic [15:0]             shots_fired_d;

`ifdef PLAYER_SHOT_AUTOFIRE_EN
    // Level-triggered: a held button keeps firing as cooldown allows.
    assign fire_event = fire_req;
`else
    // Edge-triggered: only a fresh press counts; a blocked press is lost.
    assign fire_event = fire_req & ~fire_q;
`endif

    // Lowest-index slot that was inactive at the start of the cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            if (!shot_active[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Launch qualification; the floor check keeps the spawn Y from underflowing.
    always_comb begin
        y_floor     = Y_MIN_EXT + {1'b0, PlayerS} + 11'd1;
        player_y_ok = ({1'b0, PlayerY} >= y_floor);
        launch      = enable & fire_event & (cooldown == '0) & free_found & player_y_ok;
        launch_y    = PlayerY - PlayerS - 10'd1;
    end

    // Per-slot retire/move, then drop the new shot into the allocated slot.
    always_comb begin
        active_d = shot_active;
        shot_x_d = ShotX;
        shot_y_d = ShotY;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (shot_active[i]) begin
                if (hit[i]) begin
                    active_d[i] = 1'b0;
                end else if (ShotY[i*10 +: 10] < Y_RETIRE) begin
                    active_d[i] = 1'b0;
                end else begin
                    shot_y_d[i*10 +: 10] = ShotY[i*10 +: 10] - STEP;
                end
            end
            // The allocated slot was inactive, so this never collides with a move.
            if (launch && (free_idx == IDX_W'(i))) begin
                active_d[i]          = 1'b1;
                shot_x_d[i*10 +: 10] = PlayerX;
                shot_y_d[i*10 +: 10] = launch_y;
            end
        end
    end

    // Cooldown countdown/reload and saturating launch counter.
    always_comb begin
        cooldown_d    = cooldown;
        shots_fired_d = shots_fired;
        if (launch) begin
            cooldown_d = CD_LOAD;
            if (shots_fired != 16'hFFFF) begin
                shots_fired_d = shots_fired + 16'd1;
            end
        end else if (cooldown != '0) begin
            cooldown_d = cooldown - CD_W'(1);
        end
    end

    // State update; fire_q tracks the button even while the game is paused.
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            shot_active <= '0;
            ShotX       <= '0;
            ShotY       <= '0;
            cooldown    <= '0;
            shots_fired <= '0;
            fire_ack    <= 1'b0;
            // Treat the button as already held so a press spanning reset is ignored.
            fire_q      <= 1'b1;
        end else begin
            fire_q   <= fire_req;
            fire_ack <= launch;
            if (enable) begin
                shot_active <= active_d;
                ShotX       <= shot_x_d;
                ShotY       <= shot_y_d;
                cooldown    <= cooldown_d;
                shots_fired <= shots_fired_d;
            end
        end
    end

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Directed self-checking bench for player_shot_ctrl (default edge-fire build).
module tb_player_shot_ctrl;

    localparam int NS = 4;

    logic            frame_clk;
    logic            Reset_n;
    logic            enable;
    logic            fire_req;
    logic [9:0]      PlayerX, PlayerY, PlayerS;
    logic [NS-1:0]   hit;
    logic [NS*10-1:0] ShotX, ShotY;
    logic [NS-1:0]   shot_active;
    logic            fire_ack;
    logic [15:0]     shots_fired;

    int checks = 0;
    int errors = 0;

    player_shot_ctrl #(
        .NUM_SHOTS (NS),
        .SHOT_STEP (4),
        .COOLDOWN  (8),
        .SHOT_Y_MIN(0)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .enable     (enable),
        .fire_req   (fire_req),
        .PlayerX    (PlayerX),
        .PlayerY    (PlayerY),
        .PlayerS    (PlayerS),
        .hit        (hit),
        .ShotX      (ShotX),
        .ShotY      (ShotY),
        .shot_active(shot_active),
        .fire_ack   (fire_ack),
        .shots_fired(shots_fired)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Advance one frame; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    function automatic logic [9:0] sy(input int i);
        return ShotY[i*10 +: 10];
    endfunction

    function automatic logic [9:0] sx(input int i);
        return ShotX[i*10 +: 10];
    endfunction

    // Reset, then one idle frame so the fire history is low again.
    task automatic reset_dut();
        Reset_n  = 1'b0;
        fire_req = 1'b0;
        hit      = '0;
        enable   = 1'b1;
        step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        fire_req = 1'b1;
        Reset_n  = 1'b0;
        step();
        checks++;
        if (shot_active !== 4'b0000 || shots_fired !== 16'd0 || fire_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: active=%b fired=%0d ack=%b, want 0/0/0",
                     shot_active, shots_fired, fire_ack);
        end
        checks++;
        if (ShotX !== '0 || ShotY !== '0) begin
            errors++;
            $display("FAIL reset_pos: X=%h Y=%h, want 0", ShotX, ShotY);
        end
        Reset_n = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b0 || shot_active !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held_fire: ack=%b active=%b, want 0/0000", fire_ack, shot_active);
        end
        fire_req = 1'b0;
        step();
    endtask

    task automatic test_single_launch();
        PlayerX  = 10'd320;
        PlayerY  = 10'd240;
        PlayerS  = 10'd5;
        fire_req = 1'b1;
        step();  // launch edge t0
        checks++;
        if (shot_active !== 4'b0001 || sx(0) !== 10'd320 || sy(0) !== 10'd234) begin
            errors++;
            $display("FAIL launch_pos: active=%b X=%0d Y=%0d, want 0001 320 234",
                     shot_active, sx(0), sy(0));
        end
        checks++;
        if (fire_ack !== 1'b1 || shots_fired !== 16'd1) begin
            errors++;
            $display("FAIL launch_ack: ack=%b fired=%0d, want 1 1", fire_ack, shots_fired);
        end
        fire_req = 1'b0;
        step();  // t0+1
        checks++;
        if (fire_ack !== 1'b0 || sy(0) !== 10'd230) begin
            errors++;
            $display("FAIL move1: ack=%b Y=%0d, want 0 230", fire_ack, sy(0));
        end
        step();  // t0+2
        checks++;
        if (sy(0) !== 10'd226) begin
            errors++;
            $display("FAIL move2: Y=%0d, want 226", sy(0));
        end
    endtask

    task automatic test_cooldown_edge();
        fire_req = 1'b1;
        step();  // t0+3, cooldown busy
        checks++;
        if (fire_ack !== 1'b0 || shots_fired !== 16'd1) begin
            errors++;
            $display("FAIL cooldown_early: ack=%b fired=%0d, want 0 1", fire_ack, shots_fired);
        end
        fire_req = 1'b0;
        repeat (4) step();  // t0+4..t0+7
        fire_req = 1'b1;
        step();  // t0+8, cooldown still 1
        checks++;
        if (fire_ack !== 1'b0 || shot_active !== 4'b0001) begin
            errors++;
            $display("FAIL cooldown_last: ack=%b active=%b, want 0 0001", fire_ack, shot_active);
        end
        fire_req = 1'b0;
        step();  // t0+9
        fire_req = 1'b1;
        step();  // t0+10, cooldown expired
        checks++;
        if (fire_ack !== 1'b1 || shot_active !== 4'b0011 || sy(1) !== 10'd234
            || shots_fired !== 16'd2) begin
            errors++;
            $display("FAIL second_launch: ack=%b active=%b Y1=%0d fired=%0d, want 1 0011 234 2",
                     fire_ack, shot_active, sy(1), shots_fired);
        end
        checks++;
        if (sy(0) !== 10'd194) begin
            errors++;
            $display("FAIL slot0_travel: Y0=%0d, want 194", sy(0));
        end
        // Held button: no further edges, so no further launches.
        repeat (40) step();
        checks++;
        if (shots_fired !== 16'd2) begin
            errors++;
            $display("FAIL held_edge: fired=%0d, want 2", shots_fired);
        end
        fire_req = 1'b0;
        step();
    endtask

    task automatic test_top_exit();
        reset_dut();
        PlayerX  = 10'd50;
        PlayerY  = 10'd5;
        PlayerS  = 10'd5;
        fire_req = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b0 || shot_active !== 4'b0000) begin
            errors++;
            $display("FAIL player_too_high: ack=%b active=%b, want 0 0000", fire_ack, shot_active);
        end
        fire_req = 1'b0;
        step();
        PlayerY  = 10'd12;
        fire_req = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b1 || sy(0) !== 10'd6) begin
            errors++;
            $display("FAIL top_launch: ack=%b Y=%0d, want 1 6", fire_ack, sy(0));
        end
        fire_req = 1'b0;
        step();
        checks++;
        if (shot_active !== 4'b0001 || sy(0) !== 10'd2) begin
            errors++;
            $display("FAIL top_move: active=%b Y=%0d, want 0001 2", shot_active, sy(0));
        end
        step();
        checks++;
        if (shot_active !== 4'b0000 || shots_fired !== 16'd1) begin
            errors++;
            $display("FAIL top_retire: active=%b fired=%0d, want 0000 1", shot_active, shots_fired);
        end
    endtask

    task automatic test_pool_full();
        reset_dut();
        PlayerX = 10'd100;
        PlayerY = 10'd1000;
        PlayerS = 10'd5;
        for (int k = 0; k < NS; k++) begin
            fire_req = 1'b1;
            step();
            checks++;
            if (fire_ack !== 1'b1 || shot_active[k] !== 1'b1) begin
                errors++;
                $display("FAIL fill_slot%0d: ack=%b active=%b, want ack 1 bit set",
                         k, fire_ack, shot_active);
            end
            fire_req = 1'b0;
            repeat (8) step();
        end
        fire_req = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b0 || shots_fired !== 16'd4 || shot_active !== 4'b1111) begin
            errors++;
            $display("FAIL pool_full: ack=%b fired=%0d active=%b, want 0 4 1111",
                     fire_ack, shots_fired, shot_active);
        end
        fire_req = 1'b0;
        step();
        // Slot freed by a hit this cycle cannot be reused in the same cycle.
        hit      = 4'b0100;
        fire_req = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b0 || shot_active !== 4'b1011) begin
            errors++;
            $display("FAIL hit_same_cycle: ack=%b active=%b, want 0 1011", fire_ack, shot_active);
        end
        hit      = '0;
        fire_req = 1'b0;
        step();
        fire_req = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b1 || shot_active !== 4'b1111 || sy(2) !== 10'd994
            || sx(2) !== 10'd100 || shots_fired !== 16'd5) begin
            errors++;
            $display("FAIL refill_slot2: ack=%b active=%b Y2=%0d X2=%0d fired=%0d",
                     fire_ack, shot_active, sy(2), sx(2), shots_fired);
        end
    endtask

    task automatic test_enable();
        fire_req = 1'b0;
        enable   = 1'b0;
        repeat (10) step();
        checks++;
        if (sy(2) !== 10'd994 || fire_ack !== 1'b0 || shot_active !== 4'b1111
            || shots_fired !== 16'd5) begin
            errors++;
            $display("FAIL enable_freeze: Y2=%0d ack=%b active=%b fired=%0d, want 994 0 1111 5",
                     sy(2), fire_ack, shot_active, shots_fired);
        end
        enable = 1'b1;
        step();
        checks++;
        if (sy(2) !== 10'd990) begin
            errors++;
            $display("FAIL enable_resume: Y2=%0d, want 990", sy(2));
        end
    endtask

    task automatic test_reset_mid_flight();
        fire_req = 1'b1;
        Reset_n  = 1'b0;
        step();
        checks++;
        if (shot_active !== 4'b0000 || shots_fired !== 16'd0 || fire_ack !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset: active=%b fired=%0d ack=%b, want 0000 0 0",
                     shot_active, shots_fired, fire_ack);
        end
        Reset_n = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b0 || shot_active !== 4'b0000) begin
            errors++;
            $display("FAIL held_through_reset: ack=%b active=%b, want 0 0000",
                     fire_ack, shot_active);
        end
        fire_req = 1'b0;
        step();
        fire_req = 1'b1;
        step();
        checks++;
        if (fire_ack !== 1'b1 || shot_active !== 4'b0001 || shots_fired !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_launch: ack=%b active=%b fired=%0d, want 1 0001 1",
                     fire_ack, shot_active, shots_fired);
        end
        fire_req = 1'b0;
        step();
    endtask

    initial begin
        Reset_n  = 1'b0;
        enable   = 1'b1;
        fire_req = 1'b0;
        PlayerX  = '0;
        PlayerY  = '0;
        PlayerS  = '0;
        hit      = '0;
        test_reset();
        test_single_launch();
        test_cooldown_edge();
        test_top_exit();
        test_pool_full();
        test_enable();
        test_reset_mid_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_shot_ctrl.md
# player_shot_ctrl

Scheduler for player projectiles. It owns a fixed pool of shot slots and turns the player's fire request into shot launches at the player's current position. It rate-limits firing with a cooldown counter, advances every active shot upward once per frame, and retires shots that leave the top edge or are reported hit. It sits between the player block (fire request, position and size) and the collision/colour-mapper logic, which consume the shot positions.

## Interface
Parameters:
- NUM_SHOTS, 4: number of shot slots, 1–8.
- SHOT_STEP, 4: pixels a shot moves up per enabled frame.
- COOLDOWN, 8: frames blocked after a launch; minimum launch spacing is COOLDOWN+1 frames.
- SHOT_Y_MIN, 0: top playfield bound.

Ports:
- frame_clk  in  1  the single clock; one edge per frame.
- Reset_n  in  1  reset, synchronous and active-low.
- enable  in  1  game running; when low, all state holds.
- fire_req  in  1  player fire request, level.
- PlayerX, PlayerY  in  10 each  player centre position.
- PlayerS  in  10  player half-size.
- hit  in  NUM_SHOTS  per-slot collision; retires that slot.
- ShotX, ShotY  out  NUM_SHOTS*10 each  packed shot positions; slot i occupies [10i+9:10i].
- shot_active  out  NUM_SHOTS  slot valid.
- fire_ack  out  1  one-cycle pulse on each launch.
- shots_fired  out  16  launch count, saturates at 16'hFFFF.

## Operation
- Reset (Reset_n low at an edge) clears:
  - shot_active, ShotX, ShotY, fire_ack and shots_fired to 0.
  - The cooldown counter to 0.
  - The fire_req history register (fire_q) to 1, so a button held through reset does not fire.
- enable low: every register holds. fire_ack is 0. fire_q still samples fire_req.
- enable high: each edge evaluates the slots, the cooldown and the launch logic below.
- Per slot i, for slots active at the start of the cycle, first matching rule wins:
  1. hit[i]=1: slot cleared.
  2. ShotY[i] < SHOT_Y_MIN + SHOT_STEP: slot cleared, because it has left the top.
  3. Otherwise: ShotY[i] -= SHOT_STEP. ShotX is unchanged.
- hit[i] on an inactive slot is ignored.
- Cooldown: if nonzero, decrements by 1.
- Launch condition is all of:
  - A fire event (see Configuration).
  - cooldown == 0 at the start of the cycle.
  - At least one slot inactive at the start of the cycle. Slots cleared in this same cycle are not reusable until the next cycle.
  - PlayerY >= SHOT_Y_MIN + PlayerS + 1.
- On launch:
  - The lowest-index free slot is allocated.
  - ShotX = PlayerX and ShotY = PlayerY - PlayerS - 1. The shot does not move in its launch cycle.
  - cooldown is loaded with COOLDOWN.
  - fire_ack = 1 and shots_fired increments, saturating.
- A fire event that fails any condition is dropped and is not queued.
- All arithmetic is 10-bit unsigned. The comparisons above guarantee no underflow.

## Timing
- All outputs are registered.
- Launch latency: the fire event sampled at edge t produces shot_active and positions valid after edge t.
- fire_ack is high for exactly the cycle following edge t.
- Movement: a shot launched at edge t first moves at edge t+1.
- Retire latency: hit[i] sampled at edge t gives shot_active[i]=0 after edge t.
- Reset mid-flight: all shots vanish after the reset edge. No fire_ack is produced in that cycle.
- With COOLDOWN=0, a held request (autofire build) fires every enabled frame while slots are free.

## Configuration
- PLAYER_SHOT_AUTOFIRE_EN defined: fire event = fire_req high. Holding fire launches every COOLDOWN+1 frames while slots are free.
- Not defined: fire event = fire_req & ~fire_q, i.e. a rising edge. One launch per press at most; a press blocked by cooldown or a full pool is lost.

## Test plan
- Single launch: reset, PlayerX=320, PlayerY=240, PlayerS=5, one-cycle fire_req.
  - Slot 0 becomes active at (320,234); fire_ack pulses once.
  - Next frames ShotY reads 230, 226, …
- Cooldown with PLAYER_SHOT_AUTOFIRE_EN, COOLDOWN=8, fire_req held: launches at frames 0, 9, 18, 27; slots 0–3 fill in order.
- Pool full with NUM_SHOTS=4 and all active:
  - Further requests give no fire_ack.
  - Assert hit[2]: slot 2 clears; the next eligible request refills slot 2, not slot 3.
- Top exit: shot at Y=6 with SHOT_STEP=4 moves to Y=2, then clears on the following frame; shots_fired is unchanged.
- Edge mode without the macro: fire_req held 50 frames gives exactly one launch. Release, then press again after cooldown, gives a second launch.
- enable and reset:
  - enable=0 for 10 frames: positions, cooldown and fire_ack stay frozen/0.
  - Reset_n=0 mid-flight: all shot_active=0 and shots_fired=0 after one edge. Fire held through reset does not launch.
